pc_sequencer: RTL and testbench

- Owns the program counter of the single-cycle MIPS core and drives the instruction ROM address.
- Selects the next PC from sequential, branch, jump and jump-register sources, and from the fixed reset, interrupt and exception vectors.
- Latches timer interrupt requests, masks them in kernel mode (PC[31]=1) and produces the $26 (EPC) write and the instruction-squash strobe for the register file and data memory.

---
 rtl/pc_sequencer.sv | 90 +++++++++
 tb/tb_pc_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program counter sequencer for the single-cycle MIPS core.
// Picks the next PC from sequential/branch/jump/jr sources and from the
// reset, interrupt and exception vectors. Also latches timer interrupts
// and produces the EPC ($26) write and the instruction-squash strobe.
module pc_sequencer #(
  parameter logic [31:0] RESET_VEC = 32'h8000_0000,
  parameter logic [31:0] IRQ_VEC   = 32'h8000_0004,
  parameter logic [31:0] EXC_VEC   = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        irq,
  input  logic        undef_op,
  input  logic        branch_taken,
  input  logic [15:0] imm16,
  input  logic        jump,
  input  logic [25:0] jtarget,
  input  logic        jr,
  input  logic [31:0] jr_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        kernel,
  output logic        squash,
  output logic        epc_we,
  output logic [31:0] epc_data,
  output logic        irq_pending
);

  logic        irq_q;
  logic        irq_rise;
  logic        take_exc;
  logic        take_irq;
  logic [30:0] br_offset;
  logic [30:0] br_sum;
  logic [31:0] pc_next;

  // Bit 31 is the kernel flag; sequential arithmetic wraps within [30:0]
  // so a carry can never enter or leave kernel mode.
  always_comb begin
    kernel    = pc[31];
    pc_plus4  = {pc[31], pc[30:0] + 31'd4};
    br_offset = {{13{imm16[15]}}, imm16, 2'b00};
    br_sum    = pc_plus4[30:0] + br_offset;
    irq_rise  = irq & ~irq_q;
    take_exc  = undef_op & ~kernel;
    take_irq  = irq_pending & ~kernel & ~undef_op;
  end

  // Vector takes, squash/EPC strobes and next-PC selection.
  always_comb begin
    squash   = undef_op | take_irq;
    epc_we   = take_exc | take_irq;
    epc_data = 32'h0000_0000;
    pc_next  = pc_plus4;
    if (take_exc) begin
      pc_next  = EXC_VEC;
      epc_data = pc_plus4;
    end else if (take_irq) begin
      // EPC holds the cancelled instruction so jr $26 re-executes it.
      pc_next  = IRQ_VEC;
      epc_data = pc;
    end else if (undef_op) begin
      // Undefined op inside kernel: dropped, just step past it.
      pc_next = pc_plus4;
    end else if (jr) begin
      pc_next = jr_addr;
    end else if (jump) begin
      pc_next = {pc[31], pc_plus4[30:28], jtarget, 2'b00};
    end else if (branch_taken) begin
      pc_next = {pc[31], br_sum};
    end
  end

  // PC register and interrupt edge/pending latch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_VEC;
      irq_q       <= 1'b0;
      irq_pending <= 1'b0;
    end else begin
      pc    <= pc_next;
      irq_q <= irq;
      if (take_irq)
        irq_pending <= 1'b0;
      else if (irq_rise)
        irq_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: hand-computed PC and strobe values.
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        irq;
  logic        undef_op;
  logic        branch_taken;
  logic [15:0] imm16;
  logic        jump;
  logic [25:0] jtarget;
  logic        jr;
  logic [31:0] jr_addr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        kernel;
  logic        squash;
  logic        epc_we;
  logic [31:0] epc_data;
  logic        irq_pending;

  int tests  = 0;
  int failed = 0;

  pc_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .irq          (irq),
    .undef_op     (undef_op),
    .branch_taken (branch_taken),
    .imm16        (imm16),
    .jump         (jump),
    .jtarget      (jtarget),
    .jr           (jr),
    .jr_addr      (jr_addr),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .kernel       (kernel),
    .squash       (squash),
    .epc_we       (epc_we),
    .epc_data     (epc_data),
    .irq_pending  (irq_pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        failed++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; irq = 1'b0; undef_op = 1'b0; branch_taken = 1'b0;
    imm16 = 16'h0; jump = 1'b0; jtarget = 26'h0; jr = 1'b0; jr_addr = 32'h0;
    #2;
    chk("rst_pc", pc, 32'h8000_0000);
    chk("rst_kernel", {31'd0, kernel}, 32'd1);
    chk("rst_squash", {31'd0, squash}, 32'd0);
    chk("rst_epc_we", {31'd0, epc_we}, 32'd0);
    chk("rst_epc_data", epc_data, 32'h0);
    chk("rst_pending", {31'd0, irq_pending}, 32'd0);
    chk("rst_pc_plus4", pc_plus4, 32'h8000_0004);
    #1 reset = 1'b0;
    step(); step(); step();
    chk("seq3_pc", pc, 32'h8000_000C);

    // Drop to user mode at 0x40.
    jr = 1'b1; jr_addr = 32'h0000_0040;
    step();
    jr = 1'b0;
    chk("jr_user_pc", pc, 32'h0000_0040);
    chk("jr_user_kernel", {31'd0, kernel}, 32'd0);

    jump = 1'b1; jtarget = 26'h15;
    step();
    jump = 1'b0;
    chk("jump_pc", pc, 32'h0000_0054);

    // Backward branch; irq rises in the same cycle so it latches as pc hits 0x50.
    branch_taken = 1'b1; imm16 = 16'hFFFE; irq = 1'b1;
    step();
    branch_taken = 1'b0; imm16 = 16'h0;
    chk("branch_pc", pc, 32'h0000_0050);
    chk("irq_latched", {31'd0, irq_pending}, 32'd1);
    chk("irq_squash", {31'd0, squash}, 32'd1);
    chk("irq_epc_we", {31'd0, epc_we}, 32'd1);
    chk("irq_epc_data", epc_data, 32'h0000_0050);
    step();
    chk("irq_vec_pc", pc, 32'h8000_0004);
    chk("irq_cleared", {31'd0, irq_pending}, 32'd0);
    chk("irq_vec_squash", {31'd0, squash}, 32'd0);

    // Interrupt rising in kernel mode stays pending.
    irq = 1'b0;
    step();
    irq = 1'b1;
    step();
    chk("kirq_pc", pc, 32'h8000_000C);
    chk("kirq_pending", {31'd0, irq_pending}, 32'd1);
    chk("kirq_epc_we", {31'd0, epc_we}, 32'd0);
    step();
    chk("kirq_hold_pc", pc, 32'h8000_0010);
    chk("kirq_hold_pending", {31'd0, irq_pending}, 32'd1);
    jr = 1'b1; jr_addr = 32'h0000_0050;
    step();
    jr = 1'b0;
    chk("kret_pc", pc, 32'h0000_0050);
    chk("kret_squash", {31'd0, squash}, 32'd1);
    chk("kret_epc_we", {31'd0, epc_we}, 32'd1);
    chk("kret_epc_data", epc_data, 32'h0000_0050);
    step();
    chk("kret_vec_pc", pc, 32'h8000_0004);
    chk("kret_pending", {31'd0, irq_pending}, 32'd0);

    // Undefined op in user mode.
    jr = 1'b1; jr_addr = 32'h0000_0100;
    step();
    jr = 1'b0;
    undef_op = 1'b1;
    #1;
    chk("exc_squash", {31'd0, squash}, 32'd1);
    chk("exc_epc_we", {31'd0, epc_we}, 32'd1);
    chk("exc_epc_data", epc_data, 32'h0000_0104);
    step();
    chk("exc_vec_pc", pc, 32'h8000_0008);
    // Same stimulus in kernel mode: squash only, advance by 4.
    chk("kexc_squash", {31'd0, squash}, 32'd1);
    chk("kexc_epc_we", {31'd0, epc_we}, 32'd0);
    step();
    undef_op = 1'b0;
    chk("kexc_pc", pc, 32'h8000_000C);

    // Wrap of [30:0] without touching bit 31.
    jr = 1'b1; jr_addr = 32'h7FFF_FFFC;
    step();
    jr = 1'b0;
    chk("wrap_pc_plus4", pc_plus4, 32'h0000_0000);
    step();
    chk("wrap_pc", pc, 32'h0000_0000);
    jr = 1'b1; jr_addr = 32'hFFFF_FFFC;
    step();
    jr = 1'b0;
    chk("kwrap_pc_plus4", pc_plus4, 32'h8000_0000);
    step();
    chk("kwrap_pc", pc, 32'h8000_0000);

    // Undefined op together with a pending interrupt: exception wins.
    irq = 1'b0;
    step();
    irq = 1'b1;
    step();
    chk("combo_pending_k", {31'd0, irq_pending}, 32'd1);
    jr = 1'b1; jr_addr = 32'h0000_0100;
    step();
    jr = 1'b0;
    undef_op = 1'b1;
    #1;
    chk("combo_epc_data", epc_data, 32'h0000_0104);
    step();
    undef_op = 1'b0;
    chk("combo_pc", pc, 32'h8000_0008);
    chk("combo_pending", {31'd0, irq_pending}, 32'd1);

    // Asynchronous reset mid-cycle.
    #2 reset = 1'b1;
    #1;
    chk("async_rst_pc", pc, 32'h8000_0000);
    chk("async_rst_pending", {31'd0, irq_pending}, 32'd0);
    reset = 1'b0;
    irq = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
